binary_counter: RTL and testbench

BINARY_COUNTER -- requirements
Module: binary_counter

---
 rtl/binary_counter.sv | 24 ++
 tb/tb_binary_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/binary_counter.sv
// Free-running WIDTH-bit up counter.
// Asynchronous active-low reset; count is driven straight from the register.
module binary_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Natural overflow of the adder gives the modular wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_binary_counter.sv
// Bench for binary_counter at WIDTH 4, 8 and 1.
// Table vectors plus a queued reference model per clock step.
module tb_binary_counter;

  logic       clk;
  logic       rst;
  logic [3:0] count4;
  logic [7:0] count8;
  logic [0:0] count1;

  binary_counter #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .count (count4)
  );

  binary_counter #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .count (count8)
  );

  binary_counter #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .count (count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] e4;
    logic [7:0] e8;
    logic [0:0] e1;
  } exp_t;

  vec_t tbl [22];
  exp_t sb [$];

  logic [3:0] m4;
  logic [7:0] m8;
  logic [0:0] m1;

  int checks;
  int errors;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called on a falling edge; drives rst, advances the model,
  // then compares one cycle later just after the rising edge.
  task automatic step(input logic r, input string tag,
                      input bit use_e4, input logic [3:0] e4);
    exp_t it;
    exp_t got;
    rst = r;
    if (!r) begin
      m4 = '0;
      m8 = '0;
      m1 = '0;
    end else begin
      m4 = m4 + 4'd1;
      m8 = m8 + 8'd1;
      m1 = m1 + 1'b1;
    end
    it.tag = tag;
    it.e4  = use_e4 ? e4 : m4;
    it.e8  = m8;
    it.e1  = m1;
    sb.push_back(it);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.tag, "_w4"}, int'(count4), int'(got.e4));
    check({got.tag, "_w8"}, int'(count8), int'(got.e8));
    check({got.tag, "_w1"}, int'(count1), int'(got.e1));
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    m4 = '0;
    m8 = '0;
    m1 = '0;

    tbl[0] = '{1'b0, 4'd0};
    tbl[1] = '{1'b0, 4'd0};
    for (int i = 1; i <= 20; i++) begin
      tbl[i + 1] = '{1'b1, 4'(i % 16)};
    end

    // Power-up, release on a falling edge, free-run through the wrap.
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, $sformatf("vec%0d", i), 1'b1, tbl[i].exp);
    end
    check("freerun20", int'(count4), 4);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, "run", 1'b0, 4'd0);
    end
    check("at_ten", int'(count4), 10);

    // Asynchronous clear between edges.
    #2;
    rst = 1'b0;
    #1;
    check("async_w4", int'(count4), 0);
    check("async_w8", int'(count8), 0);
    check("async_w1", int'(count1), 0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, "hold", 1'b1, 4'd0);
    end

    step(1'b1, "rel", 1'b1, 4'd1);

    for (int i = 2; i <= 255; i++) begin
      step(1'b1, "long", 1'b0, 4'd0);
    end
    check("w8_255", int'(count8), 255);
    step(1'b1, "long", 1'b0, 4'd0);
    check("w8_wrap", int'(count8), 0);
    check("w4_256", int'(count4), 0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, "tog", 1'b0, 4'd0);
    end
    check("w1_even", int'(count1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
